cdr_phase_tracker: RTL and testbench
====================================

# cdr_phase_tracker

Receive-side digital clock-and-data-recovery loop, counterpart of the TX phase-sweeping clock source. It takes data and edge samples from the RX sampler, forms Alexander (bang-bang) early/late votes, and majority-filters them over a fixed window. It steers a 9-bit phase code into the RX `phase_interpolator`, so the recovered clock tracks the phase drift injected on the TX side. It also reports lock.

## Interface
Parameters:
- `PHASE_W`, 9: phase code width; code space is 0..2^PHASE_W-1 and wraps.
- `STEP`, 1: proportional phase step per decided window.
- `VOTE_WIN`, 16: valid samples per vote window (power of two, ≥2).
- `LOCK_CNT`, 32: consecutive quiet windows needed to declare lock.
- `UNLOCK_RUN`, 4: consecutive same-direction moves that drop lock.
- `FREQ_W`, 12: frequency integrator width (used only with the macro).
- `FREQ_SHIFT`, 4: integrator gain right-shift (used only with the macro).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `sample_valid` in 1: data/edge pair valid this cycle.
- `data_sample` in 1: centre sample of the current bit.
- `edge_sample` in 1: edge sample between the previous bit and the current bit.
- `phase_shift` out PHASE_W: phase code to the interpolator.
- `phase_update` out 1: one-cycle pulse when `phase_shift` changes.
- `locked` out 1: lock indicator.

## Operation
- Phase detector:
  - Register `d_prev` plus a `prev_valid` flag. The first valid sample after reset produces no vote.
  - No vote when `d_prev == data_sample`.
  - Transition with `edge_sample == d_prev` → EARLY.
  - Transition with `edge_sample == data_sample` → LATE.
- Vote window:
  - A signed vote accumulator adds +1 per EARLY and -1 per LATE.
  - A window counter counts every valid sample, whether or not it voted.
  - The window closes on the VOTE_WIN-th valid sample; that sample's own vote is included.
  - At close: accumulator > 0 → decision +1; < 0 → -1; == 0 → hold.
  - Accumulator and window counter clear together at close.
- Phase update:
  - New `phase_shift` = (`phase_shift` + decision·STEP [+ frequency term]) mod 2^PHASE_W.
  - Wraps in both directions (0 - 1 → 511).
  - Hold: no change and no `phase_update`.
- Lock FSM, states ACQUIRE (reset state) and LOCKED:
  - Track the last nonzero decision and `run_cnt`, the length of the current same-direction run.
  - A window is quiet if its decision is hold, is opposite to the last nonzero decision, or is the first nonzero decision since reset.
  - ACQUIRE: a quiet window increments `quiet_cnt`; a non-quiet window clears it. Go to LOCKED when `quiet_cnt` reaches LOCK_CNT.
  - LOCKED: go to ACQUIRE when `run_cnt` reaches UNLOCK_RUN; clear `quiet_cnt` on that transition.
  - `locked` = (state == LOCKED).

## Timing
- Reset values: `phase_shift` = 0, `phase_update` = 0, `locked` = 0. All internal counters, `prev_valid`, and the frequency integrator are 0.
- Latency:
  - `phase_shift` and `phase_update` change one cycle after the `sample_valid` cycle that closes the window.
  - `locked` changes in that same cycle.
- Cycles with `sample_valid` low hold all state.
- Reset asserted mid-window discards the partial window and clears `prev_valid`.

## Configuration
- `CDR_FREQ_TRACK_EN` defined:
  - Adds a signed FREQ_W-bit integrator, `freq_acc += decision` at each window close, saturating at its signed limits.
  - The phase step becomes decision·STEP + (`freq_acc` >>> FREQ_SHIFT). The integrator update and the phase update use the pre-update `freq_acc`.
  - A nonzero frequency term moves the phase even on hold windows, and `phase_update` pulses.
- `CDR_FREQ_TRACK_EN` undefined: proportional-only loop; no integrator logic is present.

## Structure
- Package `cdr_pkg` holds:
  - the phase code width constant;
  - `pd_vote_e` {PD_NONE, PD_EARLY, PD_LATE};
  - `lock_state_e` {ACQUIRE, LOCKED}.
- Sub-module `bang_bang_pd`:
  - holds the `d_prev`/`prev_valid` registers and the vote decode;
  - outputs a `pd_vote_e` per valid sample.
- The top level holds the window accumulator, phase register, lock FSM and optional integrator.

## Test plan
All scenarios use default parameters.
- Reset check: assert `reset` mid-stream → `phase_shift` = 0, `locked` = 0, `phase_update` = 0 immediately (asynchronously).
- Early step: 17 valid samples, alternating data, `edge_sample` = `d_prev` (16 EARLY votes) → `phase_shift` = 1 one cycle after the window-closing sample, single `phase_update` pulse.
- Negative wrap: one all-LATE window from reset → `phase_shift` = 511.
- Hold windows: 16 samples of constant data → no vote, `phase_shift` unchanged, no pulse. Window with 8 EARLY and 8 LATE → hold.
- Lock and unlock:
  - 32 windows alternating EARLY/LATE → `locked` = 1 after the 32nd close.
  - Then 4 consecutive EARLY windows → `locked` = 0 after the 4th close.
- With `CDR_FREQ_TRACK_EN`, continuous EARLY windows:
  - step is 1 for the first 16 windows;
  - from window 17, when `freq_acc` = 16, step is 2 per window.

Source files
------------

// File: rtl/cdr_phase_tracker_pkg.sv
// rtl/cdr_phase_tracker_pkg.sv - shared constants and types for the CDR phase tracker
package cdr_pkg;

    localparam int CDR_PHASE_W = 9;

    typedef enum logic [1:0] {
        PD_NONE  = 2'd0,
        PD_EARLY = 2'd1,
        PD_LATE  = 2'd2
    } pd_vote_e;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } lock_state_e;

endpackage

// File: rtl/cdr_phase_tracker_pd.sv
// rtl/cdr_phase_tracker_pd.sv - Alexander bang-bang phase detector, one vote per valid sample
import cdr_pkg::*;

module bang_bang_pd (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_sample_valid,
    input  logic     i_data_sample,
    input  logic     i_edge_sample,
    output pd_vote_e o_vote
);

    logic r_d_prev;
    logic r_prev_valid;

    // Remember the previous data bit; the first sample after reset has no predecessor
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_d_prev     <= 1'b0;
            r_prev_valid <= 1'b0;
        end else if (i_sample_valid) begin
            r_d_prev     <= i_data_sample;
            r_prev_valid <= 1'b1;
        end
    end

    // Vote only on a data transition: edge matching the old bit means we sample early
    always_comb begin
        o_vote = PD_NONE;
        if (i_sample_valid && r_prev_valid && (r_d_prev != i_data_sample)) begin
            o_vote = (i_edge_sample == r_d_prev) ? PD_EARLY : PD_LATE;
        end
    end

endmodule

// File: rtl/cdr_phase_tracker.sv
// rtl/cdr_phase_tracker.sv - CDR loop: vote window, phase code, lock FSM; CDR_FREQ_TRACK_EN adds an integrator
import cdr_pkg::*;

module cdr_phase_tracker #(
    parameter int PHASE_W    = CDR_PHASE_W,
    parameter int STEP       = 1,
    parameter int VOTE_WIN   = 16,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_RUN = 4
`ifdef CDR_FREQ_TRACK_EN
    ,
    parameter int FREQ_W     = 12,
    parameter int FREQ_SHIFT = 4
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_sample_valid,
    input  logic               i_data_sample,
    input  logic               i_edge_sample,
    output logic [PHASE_W-1:0] o_phase_shift,
    output logic               o_phase_update,
    output logic               o_locked
);

    localparam int CW = $clog2(VOTE_WIN);
    localparam int AW = CW + 2;
    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);

    localparam logic signed [AW-1:0] ACC_ONE  = 1;
    localparam logic signed [1:0]    DEC_UP   = 2'sb01;
    localparam logic signed [1:0]    DEC_DN   = 2'sb11;
    localparam logic signed [1:0]    DEC_HOLD = 2'sb00;

    pd_vote_e              w_vote;
    logic [CW-1:0]         r_win_cnt;
    logic signed [AW-1:0]  r_acc;
    logic signed [AW-1:0]  w_acc_next;
    logic                  w_close;
    logic signed [1:0]     w_dec;
    logic [PHASE_W-1:0]    r_phase;
    logic [PHASE_W-1:0]    w_step;
    logic                  r_update;
    lock_state_e           r_state;
    logic [QW-1:0]         r_quiet_cnt;
    logic [RW-1:0]         r_run_cnt;
    logic [RW-1:0]         w_run_next;
    logic signed [1:0]     r_last_dec;
    logic                  w_same;
    logic                  w_quiet;

    bang_bang_pd u_pd (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_sample_valid (i_sample_valid),
        .i_data_sample  (i_data_sample),
        .i_edge_sample  (i_edge_sample),
        .o_vote         (w_vote)
    );

    // Fold this sample's vote in and decide the window on its last valid sample
    always_comb begin
        w_acc_next = r_acc;
        case (w_vote)
            PD_EARLY: w_acc_next = r_acc + ACC_ONE;
            PD_LATE:  w_acc_next = r_acc - ACC_ONE;
            default:  w_acc_next = r_acc;
        endcase
        w_close = i_sample_valid && (r_win_cnt == CW'(VOTE_WIN - 1));
        w_dec   = DEC_HOLD;
        if (w_close) begin
            if (w_acc_next[AW-1])
                w_dec = DEC_DN;
            else if (w_acc_next != '0)
                w_dec = DEC_UP;
        end
    end

    // Window counter wraps naturally (power-of-two window); accumulator restarts at close
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_win_cnt <= '0;
            r_acc     <= '0;
        end else if (i_sample_valid) begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_acc     <= w_close ? '0 : w_acc_next;
        end
    end

`ifdef CDR_FREQ_TRACK_EN
    localparam logic signed [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
    localparam logic signed [FREQ_W-1:0] FREQ_MIN = {1'b1, {(FREQ_W-1){1'b0}}};

    logic signed [FREQ_W-1:0] r_freq_acc;
    logic [PHASE_W-1:0]       w_fterm;

    // Integrator shifted right arithmetically, then sign-extended or truncated to phase width
    always_comb begin
        w_fterm = '0;
        for (int i = 0; i < PHASE_W; i++) begin
            w_fterm[i] = r_freq_acc[(i + FREQ_SHIFT < FREQ_W) ? (i + FREQ_SHIFT) : (FREQ_W - 1)];
        end
    end

    // Saturating frequency integrator, stepped by each window decision
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_freq_acc <= '0;
        end else if (w_close) begin
            if ((w_dec == DEC_UP) && (r_freq_acc != FREQ_MAX))
                r_freq_acc <= r_freq_acc + 1'b1;
            else if ((w_dec == DEC_DN) && (r_freq_acc != FREQ_MIN))
                r_freq_acc <= r_freq_acc - 1'b1;
        end
    end
`endif

    // Phase step in modulo-2^PHASE_W arithmetic so negative steps wrap downward
    always_comb begin
        w_step = '0;
        if (w_dec == DEC_UP)
            w_step = PHASE_W'(STEP);
        else if (w_dec == DEC_DN)
            w_step = PHASE_W'(0) - PHASE_W'(STEP);
`ifdef CDR_FREQ_TRACK_EN
        w_step = w_step + w_fterm;
`endif
    end

    // Apply the step at window close; pulse only when the code actually moves
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase  <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_close && (w_step != '0);
            if (w_close)
                r_phase <= r_phase + w_step;
        end
    end

    // Run tracking: a repeat of the last nonzero direction lengthens the run, anything else is quiet
    always_comb begin
        w_same     = (w_dec != DEC_HOLD) && (w_dec == r_last_dec);
        w_quiet    = !w_same;
        w_run_next = r_run_cnt;
        if (w_dec != DEC_HOLD) begin
            if (!w_same)
                w_run_next = RW'(1);
            else if (r_run_cnt != RW'(UNLOCK_RUN))
                w_run_next = r_run_cnt + 1'b1;
        end
    end

    // Lock FSM: enough quiet windows lock, a long one-sided run unlocks
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ACQUIRE;
            r_quiet_cnt <= '0;
            r_run_cnt   <= '0;
            r_last_dec  <= DEC_HOLD;
        end else if (w_close) begin
            r_run_cnt <= w_run_next;
            if (w_dec != DEC_HOLD)
                r_last_dec <= w_dec;
            case (r_state)
                ACQUIRE: begin
                    if (w_quiet) begin
                        r_quiet_cnt <= r_quiet_cnt + 1'b1;
                        if ((r_quiet_cnt + 1'b1) == QW'(LOCK_CNT))
                            r_state <= LOCKED;
                    end else begin
                        r_quiet_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (w_run_next == RW'(UNLOCK_RUN)) begin
                        r_state     <= ACQUIRE;
                        r_quiet_cnt <= '0;
                    end
                end
                default: r_state <= ACQUIRE;
            endcase
        end
    end

    assign o_phase_shift  = r_phase;
    assign o_phase_update = r_update;
    assign o_locked       = (r_state == LOCKED);

endmodule

// File: tb/tb_cdr_phase_tracker.sv
// tb/tb_cdr_phase_tracker.sv - scoreboard bench for cdr_phase_tracker
module tb_cdr_phase_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic       data_sample = 1'b0;
    logic       edge_sample = 1'b0;
    logic [8:0] phase_shift;
    logic       phase_update;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [8:0] phase;
        logic       upd;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];

    bit m_dprev, m_pv, m_locked;
    int m_acc, m_cnt, m_phase, m_last, m_run, m_qc, m_freq;

    cdr_phase_tracker dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_sample_valid (sample_valid),
        .i_data_sample  (data_sample),
        .i_edge_sample  (edge_sample),
        .o_phase_shift  (phase_shift),
        .o_phase_update (phase_update),
        .o_locked       (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_dprev = 0; m_pv = 0; m_locked = 0;
        m_acc = 0; m_cnt = 0; m_phase = 0; m_last = 0; m_run = 0; m_qc = 0; m_freq = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // kind: 0 = no transition, 1 = EARLY, 2 = LATE
    task automatic send(input int kind, output bit closed);
        bit d, e;
        int v, dec, step, quiet;
        exp_t x;
        d = (kind == 0) ? m_dprev : !m_dprev;
        e = (kind == 1) ? m_dprev : d;
        v = 0;
        if (m_pv && d != m_dprev) v = (e == m_dprev) ? 1 : -1;
        m_dprev = d; m_pv = 1;
        m_acc += v; m_cnt++;
        closed = (m_cnt == 16);
        if (closed) begin
            dec = (m_acc > 0) ? 1 : (m_acc < 0) ? -1 : 0;
            m_acc = 0; m_cnt = 0;
            step = dec;
`ifdef CDR_FREQ_TRACK_EN
            step += (m_freq >>> 4);
            if (dec > 0 && m_freq < 2047) m_freq++;
            if (dec < 0 && m_freq > -2048) m_freq--;
`endif
            m_phase = (m_phase + step) % 512;
            if (m_phase < 0) m_phase += 512;
            quiet = (dec == 0) || (m_last == 0) || (dec == -m_last);
            if (dec != 0) begin
                m_run = (dec == m_last) ? ((m_run < 4) ? m_run + 1 : 4) : 1;
                m_last = dec;
            end
            if (!m_locked) begin
                m_qc = quiet ? m_qc + 1 : 0;
                if (m_qc == 32) m_locked = 1;
            end else if (m_run == 4) begin
                m_locked = 0; m_qc = 0;
            end
            x.phase = 9'(m_phase);
            x.upd = ((step % 512) != 0);
            x.locked = m_locked;
            exp_q.push_back(x);
        end
        @(negedge clk);
        sample_valid = 1'b1; data_sample = d; edge_sample = e;
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (phase_shift !== 9'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase_shift); end
        n_checks++; if (phase_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b expected 0", phase_update); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    endtask

    task automatic test_early_step();
        bit c;
        exp_t x;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(1, c);
            if (phase_update === 1'b1) pulses++;
            if (c) begin
                x = exp_q.pop_front();
                n_checks++; if (phase_shift !== x.phase) begin n_fail++; $display("FAIL early_phase: got %0d expected %0d", phase_shift, x.phase); end
                n_checks++; if (phase_update !== x.upd) begin n_fail++; $display("FAIL early_update: got %b expected %b", phase_update, x.upd); end
                n_checks++; if (phase_shift !== 9'd1) begin n_fail++; $display("FAIL early_phase_one: got %0d expected 1", phase_shift); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL early_pulses: got %0d expected 1", pulses); end
        n_checks++; if (phase_shift !== 9'd1) begin n_fail++; $display("FAIL early_hold_after: got %0d expected 1", phase_shift); end
    endtask

    task automatic test_negative_wrap();
        bit c;
        exp_t x;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(2, c);
            if (c) begin
                x = exp_q.pop_front();
                n_checks++; if (phase_shift !== x.phase) begin n_fail++; $display("FAIL wrap_phase: got %0d expected %0d", phase_shift, x.phase); end
                n_checks++; if (phase_shift !== 9'd511) begin n_fail++; $display("FAIL wrap_511: got %0d expected 511", phase_shift); end
                n_checks++; if (phase_update !== 1'b1) begin n_fail++; $display("FAIL wrap_update: got %b expected 1", phase_update); end
            end
        end
    endtask

    task automatic test_hold();
        bit c;
        exp_t x;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send((i < 16) ? 0 : ((i % 2) ? 2 : 1), c);
            if (phase_update === 1'b1) pulses++;
            if (c) begin
                x = exp_q.pop_front();
                n_checks++; if (phase_shift !== x.phase) begin n_fail++; $display("FAIL hold_phase: got %0d expected %0d", phase_shift, x.phase); end
                n_checks++; if (phase_shift !== 9'd0) begin n_fail++; $display("FAIL hold_zero: got %0d expected 0", phase_shift); end
            end
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL hold_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_lock_unlock();
        bit c;
        exp_t x;
        do_reset();
        for (int w = 0; w < 36; w++) begin
            for (int i = 0; i < 16; i++) begin
                send((w >= 32 || (w % 2) == 0) ? 1 : 2, c);
                if (c) begin
                    x = exp_q.pop_front();
                    n_checks++; if (phase_shift !== x.phase) begin n_fail++; $display("FAIL lock_phase w%0d: got %0d expected %0d", w, phase_shift, x.phase); end
                    n_checks++; if (locked !== x.locked) begin n_fail++; $display("FAIL lock_state w%0d: got %b expected %b", w, locked, x.locked); end
                    n_checks++; if (phase_update !== x.upd) begin n_fail++; $display("FAIL lock_update w%0d: got %b expected %b", w, phase_update, x.upd); end
                    if (w == 30) begin
                        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b expected 0", locked); end
                    end
                    if (w == 31) begin
                        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after32: got %b expected 1", locked); end
                    end
                    if (w == 34) begin
                        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL unlock_early: got %b expected 1", locked); end
                    end
                    if (w == 35) begin
                        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL unlock_after4: got %b expected 0", locked); end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midwindow();
        bit c;
        exp_t x;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            send(1, c);
            if (c) x = exp_q.pop_front();
        end
        n_checks++; if (phase_shift !== 9'd1) begin n_fail++; $display("FAIL mid_pre_phase: got %0d expected 1", phase_shift); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (phase_shift !== 9'd0) begin n_fail++; $display("FAIL async_reset_phase: got %0d expected 0", phase_shift); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL async_reset_locked: got %b expected 0", locked); end
        n_checks++; if (phase_update !== 1'b0) begin n_fail++; $display("FAIL async_reset_update: got %b expected 0", phase_update); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(2, c);
            if (c) begin
                x = exp_q.pop_front();
                n_checks++; if (phase_shift !== x.phase) begin n_fail++; $display("FAIL mid_post_phase: got %0d expected %0d", phase_shift, x.phase); end
            end
            n_checks++; if (phase_shift !== (c ? 9'd511 : 9'd0)) begin n_fail++; $display("FAIL mid_discard s%0d: got %0d expected %0d", i, phase_shift, c ? 511 : 0); end
        end
    endtask

`ifdef CDR_FREQ_TRACK_EN
    task automatic test_freq();
        bit c;
        exp_t x;
        int w = 0;
        int want;
        do_reset();
        for (int i = 0; i < 20 * 16; i++) begin
            send(1, c);
            if (c) begin
                w++;
                want = (w <= 16) ? w : 16 + 2 * (w - 16);
                x = exp_q.pop_front();
                n_checks++; if (phase_shift !== x.phase) begin n_fail++; $display("FAIL freq_phase w%0d: got %0d expected %0d", w, phase_shift, x.phase); end
                n_checks++; if (phase_shift !== 9'(want)) begin n_fail++; $display("FAIL freq_step w%0d: got %0d expected %0d", w, phase_shift, want); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_early_step();
        test_negative_wrap();
        test_hold();
        test_lock_unlock();
        test_reset_midwindow();
`ifdef CDR_FREQ_TRACK_EN
        test_freq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
